// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and the default datapath width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_DIVU  = 3'b100,
    MDU_MTHI  = 3'b101,
    MDU_MTLO  = 3'b110
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the MDU datapath.
//   mult: {acc,low} holds the partial product with the multiplier in low;
//         add the multiplicand on low[0], then shift right by one.
//   div : {acc,low} holds {remainder,quotient}; shift left by one, trial
//         subtract the divisor, keep it and set the quotient bit if it fits.
module mdu_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             iDiv,
  input  logic [WIDTH-1:0] iAcc,
  input  logic [WIDTH-1:0] iLow,
  input  logic [WIDTH-1:0] iOpnd,
  output logic [WIDTH-1:0] oAcc,
  output logic [WIDTH-1:0] oLow
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH-1:0] diff;

  // Single-step add/shift or shift/subtract, chosen by iDiv.
  always_comb begin
    sum   = {1'b0, iAcc} + (iLow[0] ? {1'b0, iOpnd} : '0);
    rem_s = {iAcc, iLow[WIDTH-1]};
    // When rem_s >= divisor the true difference fits in WIDTH bits.
    diff  = rem_s[WIDTH-1:0] - iOpnd;
    oAcc  = sum[WIDTH:1];
    oLow  = {sum[0], iLow[WIDTH-1:1]};
    if (iDiv) begin
      if (rem_s >= {1'b0, iOpnd}) begin
        oAcc = diff;
        oLow = {iLow[WIDTH-2:0], 1'b1};
      end else begin
        oAcc = rem_s[WIDTH-1:0];
        oLow = {iLow[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO
// registers. Iterative shift-add multiply and restoring divide, one bit per
// cycle, with pipeline stall while busy and flush abort.
module mdu_seq_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iValid,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iReadHi,
  input  logic             iReadLo,
  input  logic             iKill,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO,
  output logic             oBusy,
  output logic             oStall,
  output logic             oDone
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] raw_a;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  logic             op_start;
  logic             op_signed;
  logic             op_div;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_low;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Request decode and operand magnitude for signed ops.
  always_comb begin
    op_signed = (iOp == MDU_MULT) || (iOp == MDU_DIV);
    op_div    = (iOp == MDU_DIV)  || (iOp == MDU_DIVU);
    op_start  = op_signed || (iOp == MDU_MULTU) || (iOp == MDU_DIVU);
    abs_a     = (op_signed && iA[WIDTH-1]) ? (WIDTH'(0) - iA) : iA;
    abs_b     = (op_signed && iB[WIDTH-1]) ? (WIDTH'(0) - iB) : iB;
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .iDiv  (is_div),
    .iAcc  (acc),
    .iLow  (low),
    .iOpnd (opb),
    .oAcc  (step_acc),
    .oLow  (step_low)
  );

  // Two's-complement sign correction applied at commit.
  always_comb begin
    prod     = {acc, low};
    prod_fix = neg_q ? (PW'(0) - prod) : prod;
    q_fix    = neg_q ? (WIDTH'(0) - low) : low;
    r_fix    = neg_r ? (WIDTH'(0) - acc) : acc;
  end

  // Sequencer FSM, iteration counter and HI/LO architectural state.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      low      <= '0;
      opb      <= '0;
      raw_a    <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (iKill) begin
        if (state != S_IDLE) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (iValid) begin
              if (op_start) begin
                state    <= S_PREP;
                busy     <= 1'b1;
                is_div   <= op_div;
                neg_q    <= op_signed && (iA[WIDTH-1] ^ iB[WIDTH-1]);
                neg_r    <= op_signed && iA[WIDTH-1];
                div_zero <= op_div && (iB == '0);
                raw_a    <= iA;
                // Divide keeps the dividend in low; multiply keeps the multiplier there.
                low      <= op_div ? abs_a : abs_b;
                opb      <= op_div ? abs_b : abs_a;
              end else if (iOp == MDU_MTHI) begin
                hi <= iA;
              end else if (iOp == MDU_MTLO) begin
                lo <= iA;
              end
            end
          end
          S_PREP: begin
            acc   <= '0;
            cnt   <= CW'(WIDTH - 1);
            state <= S_ITER;
          end
          S_ITER: begin
            acc <= step_acc;
            low <= step_low;
            if (cnt == '0) begin
              state <= S_FIX;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_FIX: begin
            if (div_zero) begin
              hi <= raw_a;
              lo <= '1;
            end else if (is_div) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // A flush during FIX aborts the commit, so the done pulse is withheld too.
  assign oDone  = done & ~iKill;
  assign oHI    = hi;
  assign oLO    = lo;
  assign oBusy  = busy;
  assign oStall = busy & (iReadHi | iReadLo | (iValid & (iOp != MDU_NOP)));

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed vector table, random ops
// against an arithmetic reference model, and stall/kill/reset sequences.
module tb_mdu_seq_ctrl;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        iCLK;
  logic        iRST_n;
  logic        iValid;
  logic [2:0]  iOp;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iReadHi;
  logic        iReadLo;
  logic        iKill;
  logic [31:0] oHI;
  logic [31:0] oLO;
  logic        oBusy;
  logic        oStall;
  logic        oDone;

  int errors = 0;
  int checks = 0;

  mdu_seq_ctrl #(.WIDTH(32)) dut (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .iValid  (iValid),
    .iOp     (iOp),
    .iA      (iA),
    .iB      (iB),
    .iReadHi (iReadHi),
    .iReadLo (iReadLo),
    .iKill   (iKill),
    .oHI     (oHI),
    .oLO     (oLO),
    .oBusy   (oBusy),
    .oStall  (oStall),
    .oDone   (oDone)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference result {HI,LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      OP_MULT:  r = sa * sb;
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) r = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'h0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issue one iterative op, check the 34-edge latency, one-cycle done pulse and result.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bit seen;
    @(negedge iCLK);
    iValid = 1'b1; iOp = op; iA = a; iB = b;
    @(posedge iCLK);
    @(negedge iCLK);
    iValid = 1'b0; iOp = OP_NOP;
    check({name, " busy_after_accept"}, 64'(oBusy), 64'd1);
    n = 1; seen = 1'b0;
    while (!seen && n < 100) begin
      if (oDone) seen = 1'b1;
      else begin
        @(negedge iCLK);
        n++;
      end
    end
    check({name, " latency"}, 64'(n), 64'd34);
    @(negedge iCLK);
    check({name, " hi"}, 64'(oHI), 64'(ehi));
    check({name, " lo"}, 64'(oLO), 64'(elo));
    check({name, " busy_clear"}, 64'(oBusy), 64'd0);
    check({name, " done_pulse"}, 64'(oDone), 64'd0);
  endtask

  initial begin
    logic [63:0] exp64;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          n;
    bit          seen;

    iRST_n = 1'b0; iValid = 1'b0; iOp = OP_NOP; iA = '0; iB = '0;
    iReadHi = 1'b0; iReadLo = 1'b0; iKill = 1'b0;

    vecs[0] = '{"mult_neg3x7",    OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{"div_neg7by2",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{"divu_neg7by2",   OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
    vecs[3] = '{"divu_by0",       OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[4] = '{"div_ovf",        OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{"multu_max",      OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[6] = '{"div_7byneg2",    OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{"div_neg5by0",    OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8] = '{"mult_minsq",     OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9] = '{"multu_zero",     OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};

    // Reset state
    #12;
    check("rst_hi", 64'(oHI), 64'd0);
    check("rst_lo", 64'(oLO), 64'd0);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_stall", 64'(oStall), 64'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

    // Randomised ops against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      exp64 = model(rop, ra, rb);
      run_op("rand", rop, ra, rb, exp64[63:32], exp64[31:0]);
    end

    // MFHI held against a busy MULTU: stalls from its first cycle through FIX
    @(negedge iCLK);
    iValid = 1'b1; iOp = OP_MULTU; iA = 32'hFFFFFFFF; iB = 32'hFFFFFFFF;
    @(posedge iCLK);
    @(negedge iCLK);
    iValid = 1'b0; iOp = OP_NOP;
    @(negedge iCLK);
    iReadHi = 1'b1;
    #1;
    n = 0;
    while (oStall && n < 100) begin
      n++;
      @(negedge iCLK);
      #1;
    end
    check("mfhi_stall_cycles", 64'(n), 64'd33);
    check("mfhi_release_hi", 64'(oHI), 64'hFFFFFFFE);
    check("mfhi_release_lo", 64'(oLO), 64'h00000001);
    iReadHi = 1'b0;

    // MTHI presented while busy: stalled in FIX, accepted in the first idle cycle
    @(negedge iCLK);
    iValid = 1'b1; iOp = OP_MULT; iA = 32'd5; iB = 32'd6;
    @(posedge iCLK);
    @(negedge iCLK);
    iOp = OP_MTHI; iA = 32'h00000055; iB = '0;
    #1;
    n = 0; seen = 1'b0;
    while (oStall && n < 100) begin
      if (oDone) begin
        seen = 1'b1;
        check("fix_cycle_stall", 64'(oStall), 64'd1);
      end
      n++;
      @(negedge iCLK);
      #1;
    end
    check("fix_done_seen", 64'(seen), 64'd1);
    check("held_commit_lo", 64'(oLO), 64'd30);
    check("held_commit_hi", 64'(oHI), 64'd0);
    @(negedge iCLK);
    iValid = 1'b0; iOp = OP_NOP;
    check("held_mthi_hi", 64'(oHI), 64'h00000055);
    check("held_mthi_done", 64'(oDone), 64'd0);
    check("held_mthi_busy", 64'(oBusy), 64'd0);

    // MTLO then MULT killed mid-ITER
    iValid = 1'b1; iOp = OP_MTLO; iA = 32'hA5A5A5A5;
    @(negedge iCLK);
    iValid = 1'b0; iOp = OP_NOP;
    check("mtlo_lo", 64'(oLO), 64'hA5A5A5A5);
    check("mtlo_busy", 64'(oBusy), 64'd0);
    check("mtlo_done", 64'(oDone), 64'd0);
    iValid = 1'b1; iOp = OP_MULT; iA = 32'd3; iB = 32'd4;
    @(negedge iCLK);
    iValid = 1'b0; iOp = OP_NOP;
    for (int i = 0; i < 11; i++) @(negedge iCLK);
    iKill = 1'b1;
    @(negedge iCLK);
    iKill = 1'b0;
    check("kill_busy", 64'(oBusy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (oDone) seen = 1'b1;
      @(negedge iCLK);
    end
    check("kill_no_done", 64'(seen), 64'd0);
    check("kill_lo_kept", 64'(oLO), 64'hA5A5A5A5);
    check("kill_hi_kept", 64'(oHI), 64'h00000055);

    // Kill with MTHI in IDLE: not written
    iValid = 1'b1; iOp = OP_MTHI; iA = 32'hDEADBEEF; iKill = 1'b1;
    @(negedge iCLK);
    iValid = 1'b0; iOp = OP_NOP; iKill = 1'b0;
    check("kill_idle_mthi", 64'(oHI), 64'h00000055);
    check("kill_idle_busy", 64'(oBusy), 64'd0);

    // Asynchronous reset in the middle of a DIV
    iValid = 1'b1; iOp = OP_DIV; iA = 32'h00001000; iB = 32'd3;
    @(negedge iCLK);
    iValid = 1'b0; iOp = OP_NOP;
    for (int i = 0; i < 15; i++) @(negedge iCLK);
    #2;
    iRST_n = 1'b0;
    #1;
    check("async_rst_hi", 64'(oHI), 64'd0);
    check("async_rst_lo", 64'(oLO), 64'd0);
    check("async_rst_busy", 64'(oBusy), 64'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    run_op("post_rst_mult", OP_MULT, 32'd2, 32'd2, 32'd0, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the pipelined MIPS core. It replaces single-cycle combinational mult/div in the EX stage with an iterative shift-add multiplier and restoring divider. It accepts one operation at a time from EX and stalls the pipeline when a dependent instruction (MFHI/MFLO/MTHI/MTLO or another mult/div) arrives while busy. It supports a flush that aborts an in-flight operation.

Parameters:
WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
iCLK  in  1  clock, rising edge.
iRST_n  in  1  asynchronous, active-low reset.
iValid  in  1  EX presents a MDU op this cycle.
iOp  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
iA  in  WIDTH  rs operand (multiplicand/dividend/MTxx source).
iB  in  WIDTH  rt operand (multiplier/divisor).
iReadHi  in  1  MFHI in EX.
iReadLo  in  1  MFLO in EX.
iKill  in  1  flush; aborts the in-flight op.
oHI  out  WIDTH  current HI register.
oLO  out  WIDTH  current LO register.
oBusy  out  1  iterative op in progress.
oStall  out  1  hold the pipeline; the request is not accepted this cycle.
oDone  out  1  one-cycle pulse on the cycle HI/LO commit.

Behaviour:
- Reset (async assert, sync release): state IDLE; HI=LO=0; oBusy=0; oStall=0; oDone=0; iteration counter=0; internal regs=0. Reset mid-operation discards the op.
- States: IDLE -> PREP -> ITER -> FIX -> IDLE.
- IDLE: iValid with MULT/MULTU/DIV/DIVU is accepted -> PREP.
  - Signed ops latch |iA|, |iB|, result sign = iA[31]^iB[31], remainder sign = iA[31] (DIV).
  - Unsigned ops latch raw operands.
- MTHI/MTLO in IDLE: write HI/LO at the next edge. No busy; oDone is not pulsed.
- PREP: 1 cycle. Clear the accumulator, load counter = WIDTH-1 -> ITER.
- ITER: one bit per cycle for WIDTH cycles.
  - Mult: if multiplier LSB, add the multiplicand into the upper half; then shift the 2*WIDTH product right by 1.
  - Div: shift {rem,quot} left by 1; trial-subtract the divisor; on non-negative, keep the difference and set quot LSB.
  - Counter reaches 0 -> FIX.
- FIX: 1 cycle. Apply two's-complement sign correction (signed ops only). Commit {HI,LO} at the edge; oDone=1 this cycle -> IDLE.
- Latency: accept edge to commit edge = WIDTH+2 cycles (34 at default). oBusy=1 from the cycle after accept through the FIX cycle inclusive.
- Results:
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: no trap; LO=all ones, HI=iA (raw dividend), for both signed and unsigned. Full latency still applies.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- oStall (combinational) = oBusy & (iReadHi | iReadLo | (iValid & iOp!=NOP)).
  - A stalled request is held by EX and re-presented; it is accepted in the first IDLE cycle.
  - oStall is 0 during the IDLE cycle in which oBusy drops. MFHI in that cycle reads committed values.
- oHI/oLO are direct register outputs. HI/LO never show partial results mid-op.
- iKill: has priority over everything except reset. In any non-IDLE state -> IDLE next edge; HI/LO unchanged; oDone not pulsed.
  - iKill with iValid in IDLE: the op is not accepted; MTHI/MTLO are not written.
- Simultaneous iValid and commit: a FIX-cycle request is stalled (oBusy=1). It is accepted the following cycle.

Decomposition:
- Shared package mdu_pkg:
  - op encodings (MDU_NOP, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO)
  - state encodings (S_IDLE, S_PREP, S_ITER, S_FIX)
  - WIDTH default
- One sub-module, mdu_iter_step: combinational single-iteration datapath (add/shift for mult; trial-subtract/shift for div). Selected by an op-is-div bit.
- The FSM, counter, sign handling and HI/LO registers live in mdu_seq_ctrl.

Test Plan:
- MULT iA=0xFFFFFFFD (-3), iB=7 -> after 34 cycles oDone=1; HI=0xFFFFFFFF, LO=0xFFFFFFEB; oBusy low the next cycle.
- DIV iA=0xFFFFFFF9 (-7), iB=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU same operands -> LO=0x7FFFFFFC, HI=1.
- DIVU iA=0x12345678, iB=0 -> LO=0xFFFFFFFF, HI=0x12345678; latency 34 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, MFHI issued 1 cycle after accept -> oStall=1 for 33 cycles; released with HI=0xFFFFFFFE; LO=0x00000001.
- MTLO 0xA5A5A5A5, then MULT 3*4 with iKill at ITER cycle 10 -> oDone never pulses; LO stays 0xA5A5A5A5; state IDLE next cycle.
- iRST_n asserted mid-ITER of DIV -> HI=LO=0, oBusy=0 immediately (async); a new MULT 2*2 after release gives LO=4, HI=0.
